// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Handshaked MIPS pipeline stage register with a 2-entry skid
//               buffer, synchronous flush, first-exception-wins exccode merge
//               and saturating Tnew countdown.
//               Optional feature macro: PIPE_STAGE_TNEW_HOLD_EN (held entries
//               keep counting Tnew down while stalled).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int          DATA_W   = 96,
    parameter int          TNEW_W   = 3,
    parameter int          EXC_W    = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_grfwe,
    input  logic [TNEW_W-1:0] in_tnew,
    input  logic [EXC_W-1:0]  in_exc_up,
    input  logic [EXC_W-1:0]  in_exc_local,
    input  logic              in_bd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic              out_grfwe,
    output logic [TNEW_W-1:0] out_tnew,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd
);

`ifdef PIPE_STAGE_TNEW_HOLD_EN
    localparam bit TNEW_HOLD = 1'b1;
`else
    localparam bit TNEW_HOLD = 1'b0;
`endif

    localparam logic [TNEW_W-1:0] TNEW_ONE = TNEW_W'(1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   ready_q;

    logic accept;
    logic drain;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    // Captured form of the incoming instruction
    logic [EXC_W-1:0]  cap_exc;
    logic [TNEW_W-1:0] cap_tnew;
    logic              cap_grfwe;

    logic [31:0]       main_pc,    skid_pc;
    logic [DATA_W-1:0] main_data,  skid_data;
    logic              main_grfwe, skid_grfwe;
    logic [TNEW_W-1:0] main_tnew,  skid_tnew;
    logic [EXC_W-1:0]  main_exc,   skid_exc;
    logic              main_bd,    skid_bd;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] v);
        return (v == '0) ? '0 : (v - TNEW_ONE);
    endfunction

    assign out_valid = (state != S_EMPTY);
    assign in_ready  = ready_q;
    assign accept    = in_valid & ready_q;
    assign drain     = out_valid & out_ready;

    // Earliest exception wins; a faulting instruction never writes the GRF
    assign cap_exc   = (in_exc_up != '0) ? in_exc_up : in_exc_local;
    assign cap_tnew  = sat_dec(in_tnew);
    assign cap_grfwe = in_grfwe & (cap_exc == '0);

    // Next state and entry-load decisions; flush beats accept and drain
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        state_next   = S_ONE;
                        load_main_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (accept && drain) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_next = S_TWO;
                        load_skid  = 1'b1;
                    end else if (drain) begin
                        state_next = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (drain) begin
                        state_next     = S_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_next = S_EMPTY;
            endcase
        end
    end

    // State register; in_ready is registered from the next state so it never
    // depends combinationally on out_ready
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != S_TWO);
        end
    end

    // Main entry: new capture, skid promotion, or hold (optionally aging Tnew)
    always_ff @(posedge clk) begin
        if (reset) begin
            main_pc    <= RESET_PC;
            main_data  <= '0;
            main_grfwe <= 1'b0;
            main_tnew  <= '0;
            main_exc   <= '0;
            main_bd    <= 1'b0;
        end else if (load_main_in) begin
            main_pc    <= in_pc;
            main_data  <= in_data;
            main_grfwe <= cap_grfwe;
            main_tnew  <= cap_tnew;
            main_exc   <= cap_exc;
            main_bd    <= in_bd;
        end else if (load_main_skid) begin
            main_pc    <= skid_pc;
            main_data  <= skid_data;
            main_grfwe <= skid_grfwe;
            main_tnew  <= TNEW_HOLD ? sat_dec(skid_tnew) : skid_tnew;
            main_exc   <= skid_exc;
            main_bd    <= skid_bd;
        end else if (TNEW_HOLD && out_valid && !drain) begin
            main_tnew  <= sat_dec(main_tnew);
        end
    end

    // Skid entry: absorbs the instruction accepted while downstream stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            skid_pc    <= RESET_PC;
            skid_data  <= '0;
            skid_grfwe <= 1'b0;
            skid_tnew  <= '0;
            skid_exc   <= '0;
            skid_bd    <= 1'b0;
        end else if (load_skid) begin
            skid_pc    <= in_pc;
            skid_data  <= in_data;
            skid_grfwe <= cap_grfwe;
            skid_tnew  <= cap_tnew;
            skid_exc   <= cap_exc;
            skid_bd    <= in_bd;
        end else if (TNEW_HOLD && (state == S_TWO) && !drain) begin
            skid_tnew  <= sat_dec(skid_tnew);
        end
    end

    // Bubbles present RESET_PC and zeros
    assign out_pc    = out_valid ? main_pc    : RESET_PC;
    assign out_data  = out_valid ? main_data  : '0;
    assign out_grfwe = out_valid ? main_grfwe : 1'b0;
    assign out_tnew  = out_valid ? main_tnew  : '0;
    assign out_exc   = out_valid ? main_exc   : '0;
    assign out_bd    = out_valid ? main_bd    : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg: directed sequences,
//               a capture-rule vector table and randomized traffic compared
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int          DATA_W   = 96;
    localparam int          TNEW_W   = 3;
    localparam int          EXC_W    = 5;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_pc;
    logic [DATA_W-1:0] in_data;
    logic              in_grfwe;
    logic [TNEW_W-1:0] in_tnew;
    logic [EXC_W-1:0]  in_exc_up;
    logic [EXC_W-1:0]  in_exc_local;
    logic              in_bd;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [DATA_W-1:0] out_data;
    logic              out_grfwe;
    logic [TNEW_W-1:0] out_tnew;
    logic [EXC_W-1:0]  out_exc;
    logic              out_bd;

    pipe_stage_reg #(
        .DATA_W  (DATA_W),
        .TNEW_W  (TNEW_W),
        .EXC_W   (EXC_W),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_data     (in_data),
        .in_grfwe    (in_grfwe),
        .in_tnew     (in_tnew),
        .in_exc_up   (in_exc_up),
        .in_exc_local(in_exc_local),
        .in_bd       (in_bd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_data    (out_data),
        .out_grfwe   (out_grfwe),
        .out_tnew    (out_tnew),
        .out_exc     (out_exc),
        .out_bd      (out_bd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: the stage is a FIFO of at most two captured instructions
    typedef struct {
        logic [31:0]       pc;
        logic [DATA_W-1:0] data;
        logic              grfwe;
        logic [TNEW_W-1:0] tnew;
        logic [EXC_W-1:0]  exc;
        logic              bd;
    } ent_t;

    ent_t mq[$];

    function automatic ent_t capture();
        ent_t e;
        e.pc    = in_pc;
        e.data  = in_data;
        e.exc   = (in_exc_up != 0) ? in_exc_up : in_exc_local;
        e.tnew  = (in_tnew == 0) ? '0 : TNEW_W'(in_tnew - 1);
        e.grfwe = in_grfwe && (e.exc == 0);
        e.bd    = in_bd;
        return e;
    endfunction

    task automatic compare_model();
        bit mv;
        mv = (mq.size() > 0);
        chk("m_in_ready",  in_ready,  mq.size() < 2);
        chk("m_out_valid", out_valid, mv);
        chk("m_out_pc",    out_pc,    mv ? mq[0].pc    : RESET_PC);
        chk("m_out_data",  out_data,  mv ? mq[0].data  : '0);
        chk("m_out_grfwe", out_grfwe, mv ? mq[0].grfwe : 1'b0);
        chk("m_out_tnew",  out_tnew,  mv ? mq[0].tnew  : '0);
        chk("m_out_exc",   out_exc,   mv ? mq[0].exc   : '0);
        chk("m_out_bd",    out_bd,    mv ? mq[0].bd    : 1'b0);
    endtask

    // One clock: advance the model with the inputs seen at the edge, then
    // compare shortly after the edge
    task automatic step();
        bit acc, drn;
        int n;
        @(posedge clk);
        if (reset || flush) begin
            mq.delete();
        end else begin
            acc = in_valid && (mq.size() < 2);
            drn = (mq.size() > 0) && out_ready;
            if (drn) void'(mq.pop_front());
            n = mq.size();
`ifdef PIPE_STAGE_TNEW_HOLD_EN
            for (int i = 0; i < n; i++)
                if (mq[i].tnew != 0) mq[i].tnew = mq[i].tnew - 1'b1;
`endif
            if (acc) mq.push_back(capture());
        end
        #1;
        compare_model();
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [TNEW_W-1:0] t);
        in_valid     = v;
        in_pc        = pc;
        in_tnew      = t;
        in_data      = {pc, ~pc, pc ^ 32'h5a5a_a5a5};
        in_grfwe     = 1'b1;
        in_exc_up    = '0;
        in_exc_local = '0;
        in_bd        = pc[2];
    endtask

    typedef struct {
        logic [31:0]       pc;
        logic [TNEW_W-1:0] tnew;
        logic [EXC_W-1:0]  up;
        logic [EXC_W-1:0]  loc;
        logic              grfwe;
        logic [EXC_W-1:0]  exp_exc;
        logic              exp_grfwe;
        logic [TNEW_W-1:0] exp_tnew;
    } vec_t;

    vec_t vecs[6];
    logic [TNEW_W-1:0] hold_exp[3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h3010, 3'd0, 5'd0,  5'd12, 1'b1, 5'd12, 1'b0, 3'd0};
        vecs[1] = '{32'h3014, 3'd5, 5'd4,  5'd12, 1'b1, 5'd4,  1'b0, 3'd4};
        vecs[2] = '{32'h3018, 3'd3, 5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 3'd2};
        vecs[3] = '{32'h301c, 3'd7, 5'd31, 5'd0,  1'b1, 5'd31, 1'b0, 3'd6};
        vecs[4] = '{32'h3020, 3'd1, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 3'd0};
        vecs[5] = '{32'h3024, 3'd2, 5'd0,  5'd4,  1'b0, 5'd4,  1'b0, 3'd1};
`ifdef PIPE_STAGE_TNEW_HOLD_EN
        hold_exp[0] = 3'd1; hold_exp[1] = 3'd0; hold_exp[2] = 3'd0;
`else
        hold_exp[0] = 3'd2; hold_exp[1] = 3'd2; hold_exp[2] = 3'd2;
`endif

        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, 32'h0, 3'd0);
        step();
        step();
        reset = 1'b0;
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_pc",    out_pc,    32'h3000);
        chk("rst_out_data",  out_data,  '0);

        // Single instruction
        set_in(1'b1, 32'h3004, 3'd2); out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single_valid", out_valid, 1'b1);
        chk("single_pc",    out_pc,    32'h3004);
        chk("single_tnew",  out_tnew,  3'd1);
        step();
        chk("single_gone_valid", out_valid, 1'b0);
        chk("single_gone_pc",    out_pc,    32'h3000);

        // Capture-rule table
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, vecs[i].pc, vecs[i].tnew);
            in_exc_up = vecs[i].up; in_exc_local = vecs[i].loc; in_grfwe = vecs[i].grfwe;
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            chk("vec_pc",    out_pc,    vecs[i].pc);
            chk("vec_exc",   out_exc,   vecs[i].exp_exc);
            chk("vec_grfwe", out_grfwe, vecs[i].exp_grfwe);
            chk("vec_tnew",  out_tnew,  vecs[i].exp_tnew);
            step();
        end

        // Backpressure: third instruction must wait upstream
        out_ready = 1'b0;
        set_in(1'b1, 32'h3000, 3'd1);
        step();
        chk("bp_ready_one", in_ready, 1'b1);
        set_in(1'b1, 32'h3004, 3'd1);
        step();
        chk("bp_ready_two", in_ready, 1'b0);
        set_in(1'b1, 32'h3008, 3'd1);
        step();
        chk("bp_ready_held", in_ready, 1'b0);
        chk("bp_head0",      out_pc,   32'h3000);
        out_ready = 1'b1;
        step();
        chk("bp_head1",  out_pc,   32'h3004);
        chk("bp_reopen", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("bp_head2", out_pc,    32'h3008);
        chk("bp_v2",    out_valid, 1'b1);
        step();
        chk("bp_empty", out_valid, 1'b0);

        // Tnew behaviour while stalled
        out_ready = 1'b0;
        set_in(1'b1, 32'h3030, 3'd3);
        step();
        in_valid = 1'b0;
        chk("hold_tnew_cap", out_tnew, 3'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_tnew", out_tnew, hold_exp[i]);
        end
        out_ready = 1'b1;
        step();

        // Flush during a stall with a concurrent offer
        out_ready = 1'b0;
        set_in(1'b1, 32'h3034, 3'd1); step();
        set_in(1'b1, 32'h3038, 3'd1); step();
        set_in(1'b1, 32'h3040, 3'd1); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ready", in_ready,  1'b1);
        step();
        chk("flush_never", out_valid, 1'b0);

        // Reset wins over flush and a concurrent offer
        out_ready = 1'b0;
        set_in(1'b1, 32'h3044, 3'd5); step();
        set_in(1'b1, 32'h3050, 3'd5); reset = 1'b1; flush = 1'b1;
        step();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        chk("rp_valid", out_valid, 1'b0);
        chk("rp_ready", in_ready,  1'b1);
        chk("rp_pc",    out_pc,    32'h3000);
        chk("rp_tnew",  out_tnew,  3'd0);
        chk("rp_grfwe", out_grfwe, 1'b0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            in_valid     = 1'($urandom_range(0, 1));
            out_ready    = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 24) == 0);
            reset        = ($urandom_range(0, 59) == 0);
            in_pc        = $urandom;
            in_data      = {$urandom, $urandom, $urandom};
            in_tnew      = TNEW_W'($urandom_range(0, 7));
            in_exc_up    = ($urandom_range(0, 3) == 0) ? EXC_W'($urandom_range(1, 31)) : '0;
            in_exc_local = ($urandom_range(0, 3) == 0) ? EXC_W'($urandom_range(1, 31)) : '0;
            in_grfwe     = 1'($urandom_range(0, 1));
            in_bd        = 1'($urandom_range(0, 1));
            step();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register that carries one instruction's payload between two adjacent stages of the MIPS pipeline, e.g. E→M or M→W. It generalises the fixed-width stage latch with four additions: a valid/ready handshake with a 2-entry skid buffer, synchronous flush, first-exception-wins exccode merging, and saturating Tnew countdown. The upstream stage drives `in_*`, and the downstream stage and hazard unit consume `out_*`.

## Interface
- `DATA_W`, default 96: opaque payload width (IR, PC+8, ALU result, RD2, …), passed through untouched.
- `TNEW_W`, default 3: width of the Tnew field.
- `EXC_W`, default 5: width of the exccode field.
- `RESET_PC`, default 32'h00003000: PC value presented on bubbles and after reset.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: reset, synchronous, active-high.
- `flush`  in  1: synchronous kill of all held entries.
- `in_valid`  in  1: upstream offers an instruction.
- `in_ready`  out  1: stage can accept. Registered; depends only on state.
- `in_pc`  in  32: instruction PC.
- `in_data`  in  DATA_W: payload.
- `in_grfwe`  in  1: register-file write enable.
- `in_tnew`  in  TNEW_W: cycles until result ready, as seen in the upstream stage.
- `in_exc_up`  in  EXC_W: exccode inherited from earlier stages.
- `in_exc_local`  in  EXC_W: exccode raised by the upstream stage itself.
- `in_bd`  in  1: instruction is in a branch delay slot.
- `out_valid`  out  1: main entry holds an instruction.
- `out_ready`  in  1: downstream consumes the main entry.
- `out_pc`, `out_data`, `out_grfwe`, `out_tnew`, `out_exc`, `out_bd`  out: main-entry fields.

## Operation
- Storage consists of a main entry and a skid entry. State is EMPTY (neither valid), ONE (main valid), or TWO (both valid).
- Accept = `in_valid & in_ready`. Drain = `out_valid & out_ready`.
- `in_ready` is 1 in EMPTY and ONE, and 0 in TWO.
- State transitions:
  - EMPTY: accept → ONE (write main).
  - ONE: accept & drain → ONE (main overwritten with the new instruction).
  - ONE: accept & !drain → TWO (write skid).
  - ONE: !accept & drain → EMPTY.
  - TWO: drain → ONE (skid moves to main).
  - TWO: otherwise hold.
- Capture rules:
  - exc = (`in_exc_up` != 0) ? `in_exc_up` : `in_exc_local`. The earliest exception wins.
  - tnew = (`in_tnew` == 0) ? 0 : `in_tnew` − 1, a saturating decrement.
  - grfwe = `in_grfwe` & (exc == 0). A faulting instruction never writes the register file.
  - pc, data and bd are copied unchanged.
- Bubble outputs: when `out_valid` = 0, `out_pc` = RESET_PC and every other `out_*` field is 0.
- `flush` empties both entries (→ EMPTY) and discards any accept in the same cycle. `flush` takes priority over accept and drain.
- `reset` has priority over `flush`. After reset: EMPTY, `in_ready` = 1, `out_valid` = 0, `out_pc` = RESET_PC, all other outputs 0.

## Timing
- Latency: an instruction accepted on edge N appears on `out_*` after edge N, with `out_valid` = 1 during cycle N+1.
- Throughput is 1 instruction per cycle when `out_ready` is held at 1. No bubbles are inserted.
- `in_ready` falls the cycle after the stage enters TWO. The skid entry absorbs the instruction accepted on the cycle the downstream stalled, so no combinational path exists from `out_ready` to `in_ready`.
- Ordering is strict FIFO: the skid entry is never presented before main.
- A reset or flush asserted mid-stall drops both entries on that edge. `in_ready` = 1 in the next cycle.

## Configuration
- `PIPE_STAGE_TNEW_HOLD_EN` defined:
  - A held entry saturating-decrements its tnew on every edge where it is neither drained nor overwritten.
  - On a skid→main move, main receives the skid value saturating-decremented.
  - This keeps the hazard unit's Tnew accurate during stalls.
- Undefined: stored tnew stays frozen from capture until drain.

## Test plan
- Single instruction: reset, then `in_valid` = 1, `in_pc` = 0x3004, `in_tnew` = 2, `out_ready` = 1 for one cycle. Required: next cycle `out_valid` = 1, `out_pc` = 0x3004, `out_tnew` = 1. The cycle after: `out_valid` = 0, `out_pc` = 0x3000.
- Exception merge:
  - `in_exc_up` = 0, `in_exc_local` = 12 (Ov), `in_grfwe` = 1 → `out_exc` = 12, `out_grfwe` = 0.
  - `in_exc_up` = 4, `in_exc_local` = 12 → `out_exc` = 4.
- Backpressure: stream PCs 0x3000, 0x3004, 0x3008 with `out_ready` = 0 from cycle 1. Required:
  - `in_ready` = 0 after 2 accepts; 0x3008 is held upstream.
  - On raising `out_ready`, outputs appear in the order 0x3000, 0x3004, 0x3008 with no loss or duplication.
- Tnew hold: capture `in_tnew` = 3, then stall 3 cycles.
  - With the macro: `out_tnew` = 2, 1, 0, 0.
  - Without the macro: `out_tnew` = 2, 2, 2, 2.
- Flush during stall: state TWO, assert `flush` together with `in_valid` = 1. Required: next cycle `out_valid` = 0, `in_ready` = 1, and the flushed-cycle instruction never appears.
- Reset priority: assert `reset` and `flush` together with `in_valid` = 1 in state ONE. Required: EMPTY, and all outputs at their reset values next cycle.
